inst_fetcher: RTL and testbench
===============================

// Module: inst_fetcher
// PURPOSE
//   Instruction fetch unit that feeds the decoder through its IF_issue/IF_inst interface.
//   Fetches 32-bit words sequentially from the memory controller (one outstanding request).
//   Buffers fetched words in a circular instruction queue.
//   Issues one instruction per cycle while downstream is not stalled.
//   Flushes and restarts on a PC redirect from commit (branch/jump resolution).
// PARAMETERS
//   IQ_DEPTH   8    instruction queue entries; power of 2, >= 2
//   RESET_PC   0    fetch address after reset
// PORTS
//   clk_in           in   1   clock, rising edge
//   rst_in           in   1   asynchronous, active-high reset
//   rdy_in           in   1   global ready; low = freeze all state
//   mem_req_out      out  1   fetch request valid; held until mem_ack_in
//   mem_addr_out     out  32  fetch byte address, word aligned; stable while mem_req_out=1
//   mem_ack_in       in   1   one-cycle pulse: mem_data_in valid for the pending request
//   mem_data_in      in   32  fetched instruction word
//   issue_stall_in   in   1   RS/LSB/ROB cannot accept an instruction this cycle
//   IF_issue_out     out  1   one-cycle pulse: IF_inst_out/IF_pc_out valid for decode
//   IF_inst_out      out  32  issued instruction
//   IF_pc_out        out  32  PC of the issued instruction
//   jump_in          in   1   redirect/flush request
//   jump_pc_in       in   32  new fetch PC, word aligned
// BEHAVIOUR
//   Reset: asynchronous. Outputs and state take these values while rst_in=1:
//     - fetch_pc = RESET_PC; state = IDLE
//     - head, tail and count = 0
//     - mem_req_out, mem_addr_out, IF_issue_out, IF_inst_out and IF_pc_out = 0
//   rdy_in=0: all registers hold, except IF_issue_out, which is forced to 0 (no double issue).
//   All outputs are registered.
//   FSM:
//     - IDLE -> WAIT when count < IQ_DEPTH and jump_in=0.
//       Sets mem_req_out=1 and mem_addr_out=fetch_pc.
//     - WAIT, mem_ack_in=1:
//       write {fetch_pc, mem_data_in} at tail; tail++, count++; fetch_pc += 4 (mod 2^32);
//       mem_req_out=0; go to IDLE.
//     - WAIT, jump_in=1 and no ack: go to DROP. mem_req_out stays 1 (request is in flight).
//     - DROP, mem_ack_in=1: discard data; mem_req_out=0; go to IDLE.
//   Request occupancy: at most one request outstanding, and only if a queue slot is free.
//   A push into a full queue is therefore impossible.
//   Issue: each cycle with count>0, issue_stall_in=0, jump_in=0 and rdy_in=1:
//     - pop the head; head++, count--
//     - next cycle IF_issue_out=1 with that entry's inst/pc; otherwise IF_issue_out=0
//     - IF_inst_out and IF_pc_out hold their last values when not issuing
//   Simultaneous push and pop: count is unchanged; head and tail both advance.
//   Pointers wrap modulo IQ_DEPTH.
//   Issue latency: ack in cycle N -> entry is poppable in N+1 -> IF_issue_out=1 in N+2.
//   jump_in=1 has priority over push, pop and request:
//     - head, tail and count = 0; fetch_pc = jump_pc_in; IF_issue_out=0 next cycle
//     - IDLE: no request is issued this cycle
//     - WAIT with mem_ack_in=0: go to DROP
//     - WAIT with mem_ack_in=1: the ack is dropped; go to IDLE
//     - DROP: stay in DROP, or go to IDLE if mem_ack_in=1; the ack is dropped either way
//   First post-redirect request is issued no earlier than the cycle after jump_in.
//   Its address is jump_pc_in.
//   Reset mid-WAIT abandons the request; the memory side must tolerate this.
// TESTING
//   Reset release; mem acks 0x00500093 two cycles after req at addr 0
//     -> IF_issue_out=1, IF_inst_out=0x00500093, IF_pc_out=0, two cycles after the ack.
//   issue_stall_in=1, mem acks every request
//     -> 8 pushes (pc 0x0..0x1C), then mem_req_out stays 0.
//     Release the stall -> 8 consecutive issue pulses with pc 0x0..0x1C,
//     then fetch resumes at 0x20.
//   jump_in with jump_pc_in=0x1000 while WAIT at 0x8; late ack 0xDEADBEEF
//     -> no issue of 0xDEADBEEF; next mem_addr_out=0x1000; first issue has pc 0x1000.
//   jump_in in the same cycle as a pending pop and an ack
//     -> IF_issue_out=0 next cycle; count=0; ack dropped.
//   rdy_in low for 3 cycles with count=3
//     -> no issue pulses, fetch_pc and count unchanged; issue resumes in order afterward.
//   rst_in asserted mid-WAIT with queue non-empty
//     -> mem_req_out, IF_issue_out and mem_addr_out are 0 before the next clock edge;
//     first request after release goes to RESET_PC.

Source files
------------

// File: rtl/inst_fetcher_if.sv
// Fetch-unit bus bundle: global ready, memory fetch handshake, decode issue port
// and the commit-side redirect. The fetcher uses the master view; the memory
// controller, decoder and commit logic (or a bench) use the slave view.
interface inst_fetcher_if;
    logic        rdy_in;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ack_in;
    logic [31:0] mem_data_in;
    logic        issue_stall_in;
    logic        IF_issue_out;
    logic [31:0] IF_inst_out;
    logic [31:0] IF_pc_out;
    logic        jump_in;
    logic [31:0] jump_pc_in;

    modport master (
        input  rdy_in, mem_ack_in, mem_data_in, issue_stall_in, jump_in, jump_pc_in,
        output mem_req_out, mem_addr_out, IF_issue_out, IF_inst_out, IF_pc_out
    );

    modport slave (
        output rdy_in, mem_ack_in, mem_data_in, issue_stall_in, jump_in, jump_pc_in,
        input  mem_req_out, mem_addr_out, IF_issue_out, IF_inst_out, IF_pc_out
    );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch unit: sequential word fetch with one outstanding memory
// request, a circular instruction queue, one issue per cycle towards decode,
// and flush/restart on a redirect from commit. All outputs are registered.
module inst_fetcher #(
    parameter int unsigned IQ_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    inst_fetcher_if.master bus
);
    localparam int unsigned     PTR_W   = $clog2(IQ_DEPTH);
    localparam int unsigned     CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

    // DROP: a redirect arrived while a request was in flight; its ack is discarded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [31:0]      fetch_pc_r, fetch_pc_s;
    logic [PTR_W-1:0] head_r, head_s;
    logic [PTR_W-1:0] tail_r, tail_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             mem_req_r, mem_req_s;
    logic [31:0]      mem_addr_r, mem_addr_s;
    logic             issue_r, issue_s;
    logic [31:0]      inst_out_r, inst_out_s;
    logic [31:0]      pc_out_r, pc_out_s;
    logic             push_s;
    logic             pop_s;

    logic [31:0]      iq_inst_r [IQ_DEPTH];
    logic [31:0]      iq_pc_r   [IQ_DEPTH];

    // Next-state, queue bookkeeping and output values; redirect overrides push/pop/request
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        head_s     = head_r;
        tail_s     = tail_r;
        count_s    = count_r;
        mem_req_s  = mem_req_r;
        mem_addr_s = mem_addr_r;
        issue_s    = 1'b0;
        inst_out_s = inst_out_r;
        pc_out_s   = pc_out_r;
        push_s     = 1'b0;
        pop_s      = 1'b0;

        if (bus.rdy_in) begin
            pop_s = (count_r != '0) && !bus.issue_stall_in && !bus.jump_in;

            case (state_r)
                ST_IDLE: begin
                    // A slot must be free before a request goes out, so a push never overflows
                    if (!bus.jump_in && (count_r < DEPTH_C)) begin
                        state_s    = ST_WAIT;
                        mem_req_s  = 1'b1;
                        mem_addr_s = fetch_pc_r;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (bus.jump_in) begin
                        if (bus.mem_ack_in) begin
                            state_s   = ST_IDLE;
                            mem_req_s = 1'b0;
                        end else begin
                            state_s = ST_DROP;
                        end
                    end else if (bus.mem_ack_in) begin
                        push_s     = 1'b1;
                        fetch_pc_s = fetch_pc_r + 32'd4;
                        state_s    = ST_IDLE;
                        mem_req_s  = 1'b0;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (bus.mem_ack_in) begin
                        state_s   = ST_IDLE;
                        mem_req_s = 1'b0;
                    end else begin
                        state_s = ST_DROP;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                end
            endcase

            if (push_s) begin
                tail_s = tail_r + PTR_W'(1);
            end else begin
                tail_s = tail_r;
            end

            if (pop_s) begin
                head_s     = head_r + PTR_W'(1);
                issue_s    = 1'b1;
                inst_out_s = iq_inst_r[head_r];
                pc_out_s   = iq_pc_r[head_r];
            end else begin
                head_s = head_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase

            if (bus.jump_in) begin
                head_s     = '0;
                tail_s     = '0;
                count_s    = '0;
                fetch_pc_s = bus.jump_pc_in;
            end else begin
                fetch_pc_s = fetch_pc_s;
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    // State and output registers; with rdy_in low the defaults above hold everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            issue_r    <= 1'b0;
            inst_out_r <= 32'h0000_0000;
            pc_out_r   <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
            mem_req_r  <= mem_req_s;
            mem_addr_r <= mem_addr_s;
            issue_r    <= issue_s;
            inst_out_r <= inst_out_s;
            pc_out_r   <= pc_out_s;
        end
    end

    // Queue storage: the fetched word and its PC land at the tail
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            iq_inst_r[tail_r] <= bus.mem_data_in;
            iq_pc_r[tail_r]   <= fetch_pc_r;
        end
    end

    assign bus.mem_req_out  = mem_req_r;
    assign bus.mem_addr_out = mem_addr_r;
    assign bus.IF_issue_out = issue_r;
    assign bus.IF_inst_out  = inst_out_r;
    assign bus.IF_pc_out    = pc_out_r;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: a memory responder model, a scoreboard of expected
// {pc, inst} pairs pushed when an ack is accepted and popped on each issue
// pulse, hand-written corner-case sequences and a table of redirect runs.
module tb_inst_fetcher;
    logic clk;
    logic rst;

    inst_fetcher_if bus ();

    inst_fetcher #(.IQ_DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] jpc;
        int          ack_dly;
        bit          rand_stall;
        int          n_iss;
        logic [31:0] exp_last;
    } vec_t;

    exp_t        sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mem_on   = 1'b0;
    int          ack_dly  = 0;
    int          req_age  = 0;
    bit          drop_m   = 1'b0;
    bit          ack_man  = 1'b0;
    logic [31:0] data_man = 32'h0;
    bit          stall_s  = 1'b0;
    bit          jump_s   = 1'b0;
    bit          rdy_s    = 1'b1;
    logic [31:0] jpc_s    = 32'h0;
    bit          prev_ok  = 1'b0;
    int          n_issued = 0;
    int          n_push   = 0;
    logic [31:0] last_pc  = 32'h0;
    logic [31:0] last_inst = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pop the scoreboard on every issue pulse seen at this negedge
    task automatic check_issue();
        exp_t e;
        if (bus.IF_issue_out === 1'b1) begin
            chk("issue_gate", 32'(prev_ok), 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_unexpected: got pc %h inst %h expected no issue",
                         bus.IF_pc_out, bus.IF_inst_out);
            end else begin
                e = sb.pop_front();
                chk("issue_pc", bus.IF_pc_out, e.pc);
                chk("issue_inst", bus.IF_inst_out, e.inst);
            end
            n_issued++;
            last_pc   = bus.IF_pc_out;
            last_inst = bus.IF_inst_out;
        end
    endtask

    // One cycle: check outputs, drive inputs (memory model + scoreboard), advance to next negedge
    task automatic tick();
        logic        ack_now;
        logic [31:0] data_now;
        exp_t        e;
        check_issue();
        if (mem_on) begin
            ack_now  = rdy_s && bus.mem_req_out && (req_age >= ack_dly);
            data_now = mem_word(bus.mem_addr_out);
        end else begin
            ack_now  = ack_man;
            data_now = data_man;
        end
        if (rdy_s) begin
            if (bus.mem_req_out && !ack_now) req_age++;
            else req_age = 0;
            if (jump_s) begin
                sb.delete();
                drop_m = bus.mem_req_out && !ack_now;
            end else if (ack_now) begin
                if (!drop_m) begin
                    e.pc   = bus.mem_addr_out;
                    e.inst = data_now;
                    sb.push_back(e);
                    n_push++;
                end
                drop_m = 1'b0;
            end
        end
        bus.mem_ack_in     = ack_now;
        bus.mem_data_in    = data_now;
        bus.issue_stall_in = stall_s;
        bus.jump_in        = jump_s;
        bus.jump_pc_in     = jpc_s;
        bus.rdy_in         = rdy_s;
        prev_ok = rdy_s && !stall_s && !jump_s;
        ack_man = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_sb(input int n);
        int b = 0;
        while (sb.size() < n && b < 100) begin
            tick();
            b++;
        end
        chk("wait_sb", 32'(sb.size()), 32'(n));
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        int b = 0;
        while (bus.mem_req_out !== 1'b1 && b < 50) begin
            tick();
            b++;
        end
        chk({name, "_req"}, 32'(bus.mem_req_out), 32'd1);
        chk({name, "_addr"}, bus.mem_addr_out, exp_addr);
    endtask

    task automatic wait_issue(input int target);
        int b = 0;
        while (n_issued < target && b < 200) begin
            tick();
            b++;
        end
        chk("wait_issue", 32'(n_issued), 32'(target));
    endtask

    task automatic redirect(input logic [31:0] pc);
        jump_s = 1'b1;
        jpc_s  = pc;
        tick();
        jump_s = 1'b0;
    endtask

    initial begin
        vec_t tbl [4];
        bit   seen;
        int   tgt;
        int   b;

        tbl[0] = '{jpc: 32'h0000_0100, ack_dly: 0, rand_stall: 1'b0, n_iss: 5, exp_last: 32'h0000_0110};
        tbl[1] = '{jpc: 32'h0000_0FF8, ack_dly: 1, rand_stall: 1'b1, n_iss: 4, exp_last: 32'h0000_1004};
        tbl[2] = '{jpc: 32'hFFFF_FFF8, ack_dly: 0, rand_stall: 1'b0, n_iss: 4, exp_last: 32'h0000_0004};
        tbl[3] = '{jpc: 32'h0000_4000, ack_dly: 3, rand_stall: 1'b1, n_iss: 3, exp_last: 32'h0000_4008};

        bus.rdy_in = 1'b1; bus.mem_ack_in = 1'b0; bus.mem_data_in = 32'h0;
        bus.issue_stall_in = 1'b0; bus.jump_in = 1'b0; bus.jump_pc_in = 32'h0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #20;

        // Reset values
        chk("rst_mem_req", 32'(bus.mem_req_out), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_out, 32'h0);
        chk("rst_issue", 32'(bus.IF_issue_out), 32'd0);
        chk("rst_inst", bus.IF_inst_out, 32'h0);
        chk("rst_pc", bus.IF_pc_out, 32'h0);

        // Test 1: first fetch after reset, ack two cycles after request, issue two after ack
        @(negedge clk);
        rst = 1'b0;
        mem_on = 1'b1; ack_dly = 2; stall_s = 1'b0; rdy_s = 1'b1;
        wait_req("t1_first", 32'h0);
        b = 0;
        while (n_push < 1 && b < 20) begin
            tick();
            b++;
        end
        chk("t1_ack_seen", 32'(n_push), 32'd1);
        chk("t1_no_issue_yet", 32'(bus.IF_issue_out), 32'd0);
        tick();
        chk("t1_issue", 32'(bus.IF_issue_out), 32'd1);
        chk("t1_inst", bus.IF_inst_out, 32'h0050_0093);
        chk("t1_pc", bus.IF_pc_out, 32'h0);

        // Test 2: stalled downstream fills the queue, then 8 back-to-back issues
        stall_s = 1'b1; ack_dly = 0;
        redirect(32'h0);
        wait_sb(8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_full_no_req", 32'(bus.mem_req_out), 32'd0);
        end
        stall_s = 1'b0;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t2_issue", 32'(bus.IF_issue_out), 32'd1);
            chk("t2_pc", bus.IF_pc_out, 32'(4 * i));
            if (!seen && bus.mem_req_out === 1'b1) begin
                seen = 1'b1;
                chk("t2_resume_addr", bus.mem_addr_out, 32'h20);
            end
            tick();
        end
        chk("t2_resume_seen", 32'(seen), 32'd1);

        // Test 3: redirect while waiting at 0x8; the late ack must be discarded
        stall_s = 1'b1;
        redirect(32'h0);
        wait_sb(2);
        mem_on = 1'b0;
        wait_req("t3_wait", 32'h8);
        redirect(32'h1000);
        tick();
        chk("t3_inflight", 32'(bus.mem_req_out), 32'd1);
        chk("t3_addr_stable", bus.mem_addr_out, 32'h8);
        ack_man = 1'b1; data_man = 32'hDEAD_BEEF;
        tick();
        chk("t3_drop_done", 32'(bus.mem_req_out), 32'd0);
        mem_on = 1'b1; stall_s = 1'b0;
        wait_req("t3_redirect", 32'h1000);
        tgt = n_issued + 1;
        wait_issue(tgt);
        chk("t3_first_pc", last_pc, 32'h1000);
        chk("t3_first_inst", last_inst, mem_word(32'h1000));

        // Test 4: redirect coincides with a pending pop and an ack
        stall_s = 1'b1;
        redirect(32'h3000);
        wait_sb(2);
        mem_on = 1'b0;
        wait_req("t4_wait", 32'h3008);
        stall_s = 1'b0; ack_man = 1'b1; data_man = 32'h1111_2222;
        redirect(32'h2000);
        chk("t4_no_issue", 32'(bus.IF_issue_out), 32'd0);
        chk("t4_req_idle", 32'(bus.mem_req_out), 32'd0);
        mem_on = 1'b1;
        wait_req("t4_redirect", 32'h2000);
        tgt = n_issued + 1;
        wait_issue(tgt);
        chk("t4_first_pc", last_pc, 32'h2000);

        // Test 5: rdy_in low for 3 cycles with three queued entries
        stall_s = 1'b1;
        redirect(32'h500);
        wait_sb(3);
        mem_on = 1'b0;
        wait_req("t5_wait", 32'h50C);
        rdy_s = 1'b0; stall_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_frozen_issue", 32'(bus.IF_issue_out), 32'd0);
            chk("t5_frozen_addr", bus.mem_addr_out, 32'h50C);
            chk("t5_frozen_req", 32'(bus.mem_req_out), 32'd1);
        end
        rdy_s = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t5_issue", 32'(bus.IF_issue_out), 32'd1);
            chk("t5_pc", bus.IF_pc_out, 32'h500 + 32'(4 * i));
            tick();
        end
        mem_on = 1'b1;
        tgt = n_issued + 1;
        wait_issue(tgt);
        chk("t5_resume_pc", last_pc, 32'h50C);

        // Test 6: asynchronous reset in the middle of a request with a non-empty queue
        stall_s = 1'b1;
        redirect(32'h700);
        wait_sb(2);
        mem_on = 1'b0;
        wait_req("t6_wait", 32'h708);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(bus.mem_req_out), 32'd0);
        chk("t6_rst_issue", 32'(bus.IF_issue_out), 32'd0);
        chk("t6_rst_addr", bus.mem_addr_out, 32'h0);
        chk("t6_rst_pc", bus.IF_pc_out, 32'h0);
        sb.delete(); drop_m = 1'b0; req_age = 0; prev_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_on = 1'b1; stall_s = 1'b0;
        wait_req("t6_reset_pc", 32'h0);
        tgt = n_issued + 2;
        wait_issue(tgt);
        chk("t6_second_pc", last_pc, 32'h4);

        // Table of redirect runs: target, ack latency, stall pattern, expected last PC
        for (int i = 0; i < 4; i++) begin
            stall_s = 1'b0;
            ack_dly = tbl[i].ack_dly;
            redirect(tbl[i].jpc);
            tgt = n_issued + tbl[i].n_iss;
            b = 0;
            while (n_issued < tgt && b < 400) begin
                if (tbl[i].rand_stall) stall_s = 1'($urandom_range(0, 1));
                tick();
                b++;
            end
            stall_s = 1'b0;
            chk("tbl_count", 32'(n_issued), 32'(tgt));
            chk("tbl_last_pc", last_pc, tbl[i].exp_last);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
